shift_reg_deser: RTL and testbench
==================================

# shift_reg_deser

Parametrised serial-to-parallel deserializer and the successor to the fixed 8-bit `shiftReg`. It accepts a start pulse, then shifts in `WIDTH` data bits, each qualified by `data_en`. Shift order is selectable. An optional parity bit is checked after the data bits. The assembled word is presented on `data_out` with a one-cycle `done` strobe. It sits between a serial input source and a byte/word consumer, driven by the 50 MHz system clock.

## Interface
- `WIDTH`, 8: data bits per frame; legal range 2..32.
- `LSB_FIRST`, 1: 1 = first received bit lands in `data_out[0]`; 0 = first bit lands in `data_out[WIDTH-1]`.
- `PARITY`, 0: 0 = none; 1 = even parity bit follows the data; 2 = odd parity bit follows the data.

Ports (one clock; reset is synchronous and active-high):
- `clk_50`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  frame start request, sampled in IDLE or DONE.
- `data_en`  in  1  qualifies `serial_data`; a bit is consumed only on edges where it is 1.
- `serial_data`  in  1  serial input bit.
- `data_out`  out  WIDTH  last completed word; held until the next completion.
- `done`  out  1  one-cycle strobe; `data_out` and `parity_err` are valid while high.
- `busy`  out  1  high in SHIFT and PAR states.
- `parity_err`  out  1  parity mismatch of last frame; 0 when `PARITY`=0.

## Operation
- FSM states: IDLE, SHIFT, PAR, DONE.
- Reset, sampled at any edge and in any state:
  - state goes to IDLE; bit counter and shift register go to 0.
  - all outputs go to 0: `data_out`, `done`, `busy`, `parity_err`.
  - reset mid-frame discards the partial frame and produces no `done`.
- IDLE: `start`=1 moves to SHIFT and clears the counter. `data_en` and `serial_data` are ignored.
- SHIFT: on each edge with `data_en`=1, `serial_data` is shifted in and the counter increments.
  - `LSB_FIRST`=1: shift right, entering at bit WIDTH-1.
  - `LSB_FIRST`=0: shift left, entering at bit 0.
  - When the counter reaches `WIDTH`, go to PAR if `PARITY`≠0, otherwise to DONE.
  - `data_en`=0 stalls: no shift, no count, no timeout.
- PAR: on the first edge with `data_en`=1, sample the parity bit.
  - `parity_err` = (XOR of data bits XOR parity bit) for even parity; the inverse of that for odd parity.
  - Go to DONE.
- Output registers: `data_out` and `parity_err` load on the transition into DONE. `done` is 1 for exactly the DONE cycle.
- DONE: `start`=1 goes to SHIFT (back-to-back frame); otherwise go to IDLE.
- `start` in SHIFT or PAR is ignored. It neither restarts nor extends the frame.
- `data_out` and `parity_err` are unchanged outside completion and reset.
- The counter is $clog2(WIDTH+1) bits and never wraps, because the exit at `WIDTH` is checked before incrementing past it.

## Timing
- Let edge E0 be the edge that samples `start`=1 in IDLE.
- With `data_en` held at 1:
  - data bits are sampled at E1..E_WIDTH.
  - the parity bit, if enabled, is sampled at E_WIDTH+1.
- `done` is high in the cycle after the last sampled bit:
  - WIDTH+1 cycles after E0 without parity.
  - WIDTH+2 cycles after E0 with parity.
- Each `data_en`=0 cycle in SHIFT or PAR adds exactly one cycle of latency.
- `busy` rises in the cycle after E0 and falls in the DONE cycle.
- Back-to-back: `start`=1 during DONE puts the first bit of the next frame on the edge after DONE. There are no idle cycles between frames.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Default parameters (`WIDTH`=8, `LSB_FIRST`=1, `PARITY`=0), `data_en`=1, bits 1,0,1,0,0,1,1,0 -> `data_out`=8'h65; `done` high for one cycle, 9 cycles after the start edge.
- Same stream with `LSB_FIRST`=0 -> `data_out`=8'hA6.
- `PARITY`=1, same stream plus parity bit 0 -> `parity_err`=0, `done` 10 cycles after start. Repeat with parity bit 1 -> `parity_err`=1. With `PARITY`=2 and parity bit 0 -> `parity_err`=1.
- Default parameters, `data_en`=0 for 3 cycles after the 4th bit -> `done` 12 cycles after start, `data_out`=8'h65. A `start` pulse during the frame has no effect.
- `reset`=1 for one cycle after 4 bits -> `busy`=0, `data_out`=0, no `done`. A following full frame 8'h3C completes correctly. `WIDTH`=12 frame 12'hA5C completes the same way.
- Two back-to-back frames (8'h65 then 8'h9A) with `start` high during DONE -> two `done` strobes 9 cycles apart. `data_out` holds 8'h65 until the second strobe.

Source files
------------

// File: rtl/shift_reg_deser.sv
// Serial-to-parallel deserializer: start pulse, WIDTH qualified data bits, optional parity bit,
// then a one-cycle done strobe with the assembled word on data_out.
module shift_reg_deser #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1,
    parameter int PARITY    = 0
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic             start,
    input  logic             data_en,
    input  logic             serial_data,
    output logic [WIDTH-1:0] data_out,
    output logic             done,
    output logic             busy,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
    localparam logic ODD = (PARITY == 2);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] PAR   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] shifted;
    logic             load;
    logic             perr_d;

    always_comb begin
        if (LSB_FIRST != 0) begin
            shifted = {serial_data, sreg_q[WIDTH-1:1]};
        end else begin
            shifted = {sreg_q[WIDTH-2:0], serial_data};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        load    = 1'b0;
        perr_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (data_en) begin
                    sreg_d = shifted;
                    cnt_d  = cnt_q + CW'(1);
                    // Exit on the edge that consumes the last bit, so the count stops at WIDTH.
                    if (cnt_d == CNT_LAST) begin
                        if (PARITY != 0) begin
                            state_d = PAR;
                        end else begin
                            state_d = DONE;
                            load    = 1'b1;
                        end
                    end
                end
            end
            PAR: begin
                if (data_en) begin
                    state_d = DONE;
                    load    = 1'b1;
                    perr_d  = (^sreg_q) ^ serial_data ^ ODD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sreg_q     <= '0;
            data_out   <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            done    <= (state_d == DONE);
            busy    <= (state_d == SHIFT) || (state_d == PAR);
            if (load) begin
                data_out   <= sreg_d;
                parity_err <= perr_d;
            end
        end
    end

endmodule

// File: tb/tb_shift_reg_deser.sv
// Directed bench for shift_reg_deser: five parameter variants, each driven by its own
// stimulus lane, with hand-computed words, parity flags and done latencies.
module tb_shift_reg_deser;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_v[5];
    logic en_v[5];
    logic ser_v[5];
    logic done_v[5];
    logic busy_v[5];
    logic perr_v[5];
    logic [7:0]  d0, d1, d2, d3;
    logic [11:0] d4;
    logic [31:0] dout[5];

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    assign dout[0] = 32'(d0);
    assign dout[1] = 32'(d1);
    assign dout[2] = 32'(d2);
    assign dout[3] = 32'(d3);
    assign dout[4] = 32'(d4);

    shift_reg_deser #(.WIDTH(8), .LSB_FIRST(1), .PARITY(0)) u0 (
        .clk_50(clk), .reset(rst), .start(start_v[0]), .data_en(en_v[0]),
        .serial_data(ser_v[0]), .data_out(d0), .done(done_v[0]), .busy(busy_v[0]),
        .parity_err(perr_v[0]));
    shift_reg_deser #(.WIDTH(8), .LSB_FIRST(0), .PARITY(0)) u1 (
        .clk_50(clk), .reset(rst), .start(start_v[1]), .data_en(en_v[1]),
        .serial_data(ser_v[1]), .data_out(d1), .done(done_v[1]), .busy(busy_v[1]),
        .parity_err(perr_v[1]));
    shift_reg_deser #(.WIDTH(8), .LSB_FIRST(1), .PARITY(1)) u2 (
        .clk_50(clk), .reset(rst), .start(start_v[2]), .data_en(en_v[2]),
        .serial_data(ser_v[2]), .data_out(d2), .done(done_v[2]), .busy(busy_v[2]),
        .parity_err(perr_v[2]));
    shift_reg_deser #(.WIDTH(8), .LSB_FIRST(1), .PARITY(2)) u3 (
        .clk_50(clk), .reset(rst), .start(start_v[3]), .data_en(en_v[3]),
        .serial_data(ser_v[3]), .data_out(d3), .done(done_v[3]), .busy(busy_v[3]),
        .parity_err(perr_v[3]));
    shift_reg_deser #(.WIDTH(12), .LSB_FIRST(1), .PARITY(0)) u4 (
        .clk_50(clk), .reset(rst), .start(start_v[4]), .data_en(en_v[4]),
        .serial_data(ser_v[4]), .data_out(d4), .done(done_v[4]), .busy(busy_v[4]),
        .parity_err(perr_v[4]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle c is the clock period after edge E_{c-1}; E0 samples start. bits[i] is the i-th
    // serial bit sent; n includes the parity bit when present.
    task automatic run_frame(input int id, input logic [31:0] bits, input int n,
                             input int stall_at, input int stall_len, input bit mid_start,
                             output int done_cyc, output int n_done,
                             output logic [31:0] word, output logic perr);
        int sent   = 0;
        int stalls = 0;
        done_cyc = -1;
        n_done   = 0;
        word     = '0;
        perr     = 1'b0;
        @(negedge clk);
        start_v[id] = 1'b1;
        @(negedge clk);
        start_v[id] = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 1) check("busy_rise", 32'(busy_v[id]), 32'd1);
            if (done_v[id]) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    word     = dout[id];
                    perr     = perr_v[id];
                    check("busy_fall", 32'(busy_v[id]), 32'd0);
                end
            end
            start_v[id] = mid_start && (c == 5);
            if (sent < n && sent == stall_at && stalls < stall_len) begin
                en_v[id] = 1'b0;
                stalls++;
            end else if (sent < n) begin
                en_v[id]  = 1'b1;
                ser_v[id] = bits[sent];
                sent++;
            end else begin
                en_v[id] = 1'b0;
            end
        end
        en_v[id] = 1'b0;
    endtask

    initial begin
        int          dc, nd, cyc1, cyc2, n_rst_done;
        logic [31:0] w;
        logic        pe;
        for (int i = 0; i < 5; i++) begin
            start_v[i] = 1'b0;
            en_v[i]    = 1'b0;
            ser_v[i]   = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rst_dout%0d", i), dout[i], 32'd0);
            check($sformatf("rst_flags%0d", i),
                  32'({done_v[i], busy_v[i], perr_v[i]}), 32'd0);
        end

        // LSB first, no parity.
        run_frame(0, 32'h65, 8, -1, 0, 1'b0, dc, nd, w, pe);
        check("lsb_word", w, 32'h65);
        check("lsb_lat", 32'(dc), 32'd9);
        check("lsb_ndone", 32'(nd), 32'd1);

        // MSB first.
        run_frame(1, 32'h65, 8, -1, 0, 1'b0, dc, nd, w, pe);
        check("msb_word", w, 32'hA6);
        check("msb_lat", 32'(dc), 32'd9);

        // Even parity, good then bad parity bit.
        run_frame(2, 32'h065, 9, -1, 0, 1'b0, dc, nd, w, pe);
        check("even0_word", w, 32'h65);
        check("even0_perr", 32'(pe), 32'd0);
        check("even0_lat", 32'(dc), 32'd10);
        run_frame(2, 32'h165, 9, -1, 0, 1'b0, dc, nd, w, pe);
        check("even1_perr", 32'(pe), 32'd1);
        check("even1_hold", 32'(perr_v[2]), 32'd1);

        // Odd parity with parity bit 0: data has even weight, so mismatch.
        run_frame(3, 32'h065, 9, -1, 0, 1'b0, dc, nd, w, pe);
        check("odd0_perr", 32'(pe), 32'd1);
        check("odd0_lat", 32'(dc), 32'd10);

        // Three stall cycles after the 4th bit, plus an ignored mid-frame start.
        run_frame(0, 32'h65, 8, 4, 3, 1'b1, dc, nd, w, pe);
        check("stall_word", w, 32'h65);
        check("stall_lat", 32'(dc), 32'd12);
        check("stall_ndone", 32'(nd), 32'd1);

        // Reset after four bits discards the frame.
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            en_v[0]  = 1'b1;
            ser_v[0] = c[0];
            @(negedge clk);
        end
        en_v[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_busy", 32'(busy_v[0]), 32'd0);
        check("rstmid_dout", dout[0], 32'd0);
        n_rst_done = 0;
        for (int c = 0; c < 12; c++) begin
            en_v[0]  = 1'b1;
            ser_v[0] = 1'b1;
            if (done_v[0]) n_rst_done++;
            @(negedge clk);
        end
        en_v[0] = 1'b0;
        check("rstmid_nodone", 32'(n_rst_done), 32'd0);
        run_frame(0, 32'h3C, 8, -1, 0, 1'b0, dc, nd, w, pe);
        check("after_rst_word", w, 32'h3C);
        check("after_rst_lat", 32'(dc), 32'd9);

        // Wider frame.
        run_frame(4, 32'hA5C, 12, -1, 0, 1'b0, dc, nd, w, pe);
        check("w12_word", w, 32'hA5C);
        check("w12_lat", 32'(dc), 32'd13);

        // Back-to-back frames with start held during DONE.
        cyc1 = -1;
        cyc2 = -1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            if (c > 1) @(negedge clk);
            if (done_v[0]) begin
                if (cyc1 < 0) begin
                    cyc1 = c;
                    check("b2b_word1", dout[0], 32'h65);
                end else if (cyc2 < 0) begin
                    cyc2 = c;
                    check("b2b_word2", dout[0], 32'h9A);
                end
            end
            if (c == 13) check("b2b_hold", dout[0], 32'h65);
            if (c == 13) check("b2b_busy", 32'(busy_v[0]), 32'd1);
            start_v[0] = (c == 9);
            if (c >= 1 && c <= 8) begin
                en_v[0]  = 1'b1;
                ser_v[0] = (8'h65 >> (c - 1)) & 8'h1;
            end else if (c >= 10 && c <= 17) begin
                en_v[0]  = 1'b1;
                ser_v[0] = (8'h9A >> (c - 10)) & 8'h1;
            end else begin
                en_v[0] = 1'b0;
            end
        end
        en_v[0] = 1'b0;
        check("b2b_lat1", 32'(cyc1), 32'd9);
        check("b2b_gap", 32'(cyc2 - cyc1), 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
